// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the sequential CLA adder: FSM encodings, slice width, counter sizing.
package cla_seq_adder_pkg;

    localparam int unsigned SliceW = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Keep the counter at least 1 bit wide, even for a single chunk.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_cla8.sv
// 8-bit carry-lookahead slice: every carry is a flat generate/propagate sum-of-products.
module cla_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       carry;
    logic       prop;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c     = '0;
        c[0]  = cin;
        carry = 1'b0;
        prop  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            carry = 1'b0;
            prop  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                carry = carry | (prop & g[j]);
                prop  = prop & p[j];
            end
            c[i+1] = carry | (prop & cin);
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor reusing one cla_8 slice over WIDTH/8 passes.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CHUNKS = WIDTH / SliceW;
    localparam int unsigned CntW   = cnt_width(CHUNKS);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              carry_q, cout_q;
    logic [CntW-1:0]   cnt_q;
    logic [SliceW-1:0] f8;
    logic              c8;
    logic              accept;
    logic              last_pass;

    assign accept    = (state_q == StIdle) && in_valid;
    assign last_pass = (state_q == StRun) && (cnt_q == CntW'(CHUNKS - 1));

    cla_8 u_slice (
        .a    (a_q[SliceW-1:0]),
        .b    (b_q[SliceW-1:0]),
        .cin  (carry_q),
        .sum  (f8),
        .cout (c8)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StRun;
            StRun:   if (last_pass) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            // Results enter from the top so the first slice ends up in the low byte.
            a_q     <= {{SliceW{1'b0}}, a_q[WIDTH-1:SliceW]};
            b_q     <= {{SliceW{1'b0}}, b_q[WIDTH-1:SliceW]};
            sum_q   <= {f8, sum_q[WIDTH-1:SliceW]};
            carry_q <= c8;
            cnt_q   <= cnt_q + CntW'(1);
            if (last_pass) begin
                cout_q <= c8;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef CLA_SEQ_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (last_pass) begin
            ovf_q <= (a_msb_q == b_msb_q) && (f8[SliceW-1] != a_msb_q);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
